// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    localparam int          PC_W             = 30;
    localparam int          IW_DEFAULT       = 32;
    localparam logic [29:0] RESET_PC_DEFAULT = 30'h00000C00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Word-address PC register: plain load-enabled flop, no arithmetic of its own.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Optional stall counter output enabled by defining IFU_FETCH_PERF_EN.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              IW       = IW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] npc_in,
    output logic [PC_W-1:0] pc_out,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [IW-1:0]   imem_rdata,
    output logic            instr_valid,
    output logic [IW-1:0]   instr_out,
    output logic [PC_W-1:0] instr_pc,
`ifdef IFU_FETCH_PERF_EN
    output logic [31:0]     stall_cnt,
`endif
    input  logic            instr_ready
);

    ifu_state_t      state, state_nxt;
    logic            capture;
    logic            pc_load;
    logic [PC_W-1:0] pc;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (npc_in),
        .q     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rvalid only matters in WAIT and gnt only in REQ, which enforces one outstanding request
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        pc_load   = 1'b0;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ:   if (imem_gnt) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = VALID;
                    capture   = 1'b1;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    state_nxt = REQ;
                    pc_load   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out <= '0;
        end else if (capture) begin
            instr_out <= imem_rdata;
        end
    end

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == VALID);
    assign pc_out      = pc;
    assign imem_addr   = pc;
    assign instr_pc    = pc;

`ifdef IFU_FETCH_PERF_EN
    logic stall;

    assign stall = ((state == REQ)   && !imem_gnt)    ||
                   ((state == WAIT)  && !imem_rvalid) ||
                   ((state == VALID) && !instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFFFFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; inputs change and outputs are sampled 1ns after each rising edge.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [29:0] npc_in;
    logic [29:0] pc_out;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [29:0] instr_pc;
    logic        instr_ready;
`ifdef IFU_FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    ifu_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_in      (npc_in),
        .pc_out      (pc_out),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
`ifdef IFU_FETCH_PERF_EN
        .stall_cnt   (stall_cnt),
`endif
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch-side state expectations for the current cycle
    task automatic chk_req(input string tag, input logic [29:0] addr);
        chk({tag, ".req"},   32'(imem_req), 32'd1);
        chk({tag, ".addr"},  32'(imem_addr), 32'(addr));
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic chk_valid(input string tag, input logic [31:0] ins, input logic [29:0] pc);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".req"},   32'(imem_req), 32'd0);
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".ipc"},   32'(instr_pc), 32'(pc));
        chk({tag, ".pc"},    32'(pc_out), 32'(pc));
    endtask

    initial begin
        rst_n       = 1'b0;
        npc_in      = 30'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        step();
        step();

        chk("rst.req",   32'(imem_req), 32'd0);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instr_out, 32'h0);
        chk("rst.pc",    32'(pc_out), 32'h00000C00);

        // Basic fetch: IDLE, REQ(gnt), WAIT(rvalid), VALID
        rst_n = 1'b1;
        chk("idle.req", 32'(imem_req), 32'd0);
        step();
        chk_req("t1.req", 30'hC00);
        imem_gnt = 1'b1;
        step();
        chk("t1.wait.req", 32'(imem_req), 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3C01_1234;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t1.v", 32'h3C011234, 30'hC00);

        // Sequential accept, then npc_in wiggles while not accepting, then a branch
        npc_in      = 30'hC01;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t2.seq", 30'hC01);
        npc_in   = 30'h123;
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        npc_in      = 30'h456;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_00AA;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t2.v", 32'h000000AA, 30'hC01);
        npc_in = 30'h789;
        step();
        chk_valid("t2.hold", 32'h000000AA, 30'hC01);
        npc_in      = 30'hC05;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t2.br", 30'hC05);

        // Stalls from a fresh reset: 5 cycles without gnt, 3 cycles without rvalid
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk_req($sformatf("t3.gnt%0d", i), 30'hC00);
            step();
        end
        chk_req("t3.gnt5", 30'hC00);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3.wait%0d", i), {30'h0, imem_req, instr_valid}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5A5A_0001;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t3.v", 32'h5A5A0001, 30'hC00);
`ifdef IFU_FETCH_PERF_EN
        chk("t3.stall", stall_cnt, 32'd8);
`endif

        // Spurious rvalid in REQ (including alongside gnt) and duplicate gnt in WAIT
        npc_in      = 30'hC10;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t4.req", 30'hC10);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0000;
        step();
        chk_req("t4.spur", 30'hC10);
        chk("t4.spur.instr", instr_out, 32'h5A5A0001);
        imem_gnt   = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        step();
        imem_rvalid = 1'b0;
        chk("t4.w.req",   32'(imem_req), 32'd0);
        chk("t4.w.valid", 32'(instr_valid), 32'd0);
        step();
        chk("t4.dup.req",   32'(imem_req), 32'd0);
        chk("t4.dup.valid", 32'(instr_valid), 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t4.v", 32'hCAFEF00D, 30'hC10);

        // Reset while in WAIT, late rvalid right after release
        npc_in      = 30'hC20;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t5.req", 30'hC20);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t5.rst.req",   32'(imem_req), 32'd0);
        chk("t5.rst.valid", 32'(instr_valid), 32'd0);
        chk("t5.rst.instr", instr_out, 32'h0);
        chk("t5.rst.pc",    32'(pc_out), 32'h00000C00);
        step();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        chk_req("t5.fresh", 30'hC00);
        chk("t5.late.instr", instr_out, 32'h0);
        step();
        chk_req("t5.late2", 30'hC00);
        chk("t5.late2.instr", instr_out, 32'h0);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t5.v", 32'h11112222, 30'hC00);

        // Decode back-pressure for 10 cycles, then accept the all-ones PC
        npc_in = 30'h3FFFFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_valid($sformatf("t6.hold%0d", i), 32'h11112222, 30'hC00);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t6.max", 30'h3FFFFFFF);

        // Self-loop refetches the same address
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_8888;
        step();
        imem_rvalid = 1'b0;
        chk_valid("t7.v", 32'h77778888, 30'h3FFFFFFF);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_req("t7.loop", 30'h3FFFFFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
